// File: rtl/data_send.sv
`default_nettype none
// ============================================================================
// Module   : data_send
// Purpose  : LVDS transmit side. Software fills a word buffer over AXI4-Lite
//            and sets CR.START. The buffer is then serialized LSB-nibble
//            first on LVDS_OUT, with a forwarded clock and a frame strobe.
// Ports    : S_AXI_ACLK / S_AXI_ARESETN - clock, synchronous active-low reset
//            S_AXI_AW* / W* / B*         - AXI4-Lite write (WSTRB ignored)
//            S_AXI_AR* / R*              - AXI4-Lite read (2-cycle latency)
//            LVDS_OUT[3:0]               - data nibble
//            LVDS_CLK_OUT                - forwarded clock, rises mid-nibble
//            LVDS_FRAME                  - high for the whole transfer
// Map      : 0x000 CR (W: b0 START, b1 ABORT) | 0x004 SR (b0 BUSY, b1 DONE
//            W1C) | 0x008 LEN [7:0] | 0x200-0x3FF BUF words
// Revision : 1.0 - initial release
// ============================================================================
module data_send #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_BUF_DEPTH        = 128,
    parameter int C_CLK_DIV          = 2
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [3:0]                      LVDS_OUT,
    output logic                            LVDS_CLK_OUT,
    output logic                            LVDS_FRAME
);

    localparam int c_aw = $clog2(C_BUF_DEPTH);
    localparam int c_dw = $clog2(C_CLK_DIV);

    localparam logic [c_dw-1:0] c_div_last = c_dw'(C_CLK_DIV - 1);
    localparam logic [c_dw-1:0] c_div_half = c_dw'(C_CLK_DIV / 2);
    localparam logic [8:0]      c_depth    = 9'(C_BUF_DEPTH);

    // Word-index decode of addr[9:2]; bit 7 set selects the buffer window.
    localparam logic [7:0] c_idx_cr  = 8'h00;
    localparam logic [7:0] c_idx_sr  = 8'h01;
    localparam logic [7:0] c_idx_len = 8'h02;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_awready;
    logic              r_bvalid;
    logic              r_arready;
    logic              r_rd_p1;
    logic [7:0]        r_rd_idx;
    logic              r_rvalid;
    logic [31:0]       r_rdata;
    logic [31:0]       w_rd_mux;

    logic [31:0]       r_mem [C_BUF_DEPTH];
    logic [31:0]       r_axi_q;
    logic [31:0]       r_tx_q;
    logic [c_aw-1:0]   w_tx_raddr;

    logic [7:0]        r_len;
    logic              r_done;

    logic [c_dw-1:0]   r_div;
    logic [2:0]        r_nib;
    logic [7:0]        r_word_idx;
    logic [7:0]        w_word_idx_inc;
    logic [31:0]       r_shift;

    logic              w_wr_en;
    logic [7:0]        w_wr_idx;
    logic              w_cr_wr;
    logic              w_abort;
    logic              w_start;
    logic              w_len_ok;
    logic              w_busy;
    logic              w_rd_hs;
    logic              w_div_wrap;
    logic              w_word_end;
    logic              w_frame_end;
    logic              w_frame_done;
    logic              w_unused;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign w_wr_en        = r_awready && S_AXI_AWVALID && S_AXI_WVALID;
    assign w_wr_idx       = S_AXI_AWADDR[9:2];
    assign w_cr_wr        = w_wr_en && (w_wr_idx == c_idx_cr);
    assign w_busy         = (r_state != S_IDLE);
    assign w_len_ok       = (r_len != 8'd0) && ({1'b0, r_len} <= c_depth);
    // ABORT beats START when both arrive in the same CR write.
    assign w_abort        = w_cr_wr && S_AXI_WDATA[1];
    assign w_start        = w_cr_wr && S_AXI_WDATA[0] && !S_AXI_WDATA[1]
                            && !w_busy && w_len_ok;
    assign w_rd_hs        = r_arready && S_AXI_ARVALID;

    assign w_word_idx_inc = r_word_idx + 8'd1;
    assign w_div_wrap     = (r_div == c_div_last);
    assign w_word_end     = w_div_wrap && (r_nib == 3'd7);
    assign w_frame_end    = w_word_end && (w_word_idx_inc == r_len);
    assign w_frame_done   = (r_state == S_SHIFT) && w_frame_end && !w_abort;

    // Prefetch address: word 0 while idle, otherwise the word after the one
    // being shifted, so the next word is already in r_tx_q at each word wrap.
    assign w_tx_raddr     = (r_state == S_IDLE) ? '0 : w_word_idx_inc[c_aw-1:0];

    assign w_unused = &{1'b0, S_AXI_WSTRB,
                        S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:10], S_AXI_AWADDR[1:0],
                        S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:10], S_AXI_ARADDR[1:0]};

    // ------------------------------------------------------------------
    // AXI write channel
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_awready <= S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid && !r_awready;
            if (w_wr_en) begin
                r_bvalid <= 1'b1;
            end else if (S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_awready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = 2'b00;

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_len  <= 8'd0;
            r_done <= 1'b0;
        end else begin
            if (w_wr_en && (w_wr_idx == c_idx_len) && !w_busy) begin
                r_len <= S_AXI_WDATA[7:0];
            end
            if (w_wr_en && (w_wr_idx == c_idx_sr) && S_AXI_WDATA[1]) begin
                r_done <= 1'b0;
            end
            if (w_frame_done) begin
                r_done <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Buffer RAM: one write port, two synchronous read ports (AXI, TX)
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_wr_en && w_wr_idx[7] && !w_busy) begin
            r_mem[S_AXI_AWADDR[c_aw+1:2]] <= S_AXI_WDATA;
        end
        if (w_rd_hs) begin
            r_axi_q <= r_mem[S_AXI_ARADDR[c_aw+1:2]];
        end
        r_tx_q <= r_mem[w_tx_raddr];
    end

    // ------------------------------------------------------------------
    // AXI read channel: handshake -> RAM read -> registered RDATA
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_mux = 32'd0;
        if (r_rd_idx[7]) begin
            w_rd_mux = r_axi_q;
        end else begin
            case (r_rd_idx)
                c_idx_sr:  w_rd_mux = {30'd0, r_done, w_busy};
                c_idx_len: w_rd_mux = {24'd0, r_len};
                default:   w_rd_mux = 32'd0;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_arready <= 1'b0;
            r_rd_p1   <= 1'b0;
            r_rd_idx  <= 8'd0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            r_arready <= S_AXI_ARVALID && !r_rvalid && !r_rd_p1 && !r_arready;
            r_rd_p1   <= w_rd_hs;
            if (w_rd_hs) begin
                r_rd_idx <= S_AXI_ARADDR[9:2];
            end
            if (r_rd_p1) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
            end else if (S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = 2'b00;

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        LVDS_OUT     = 4'd0;
        LVDS_CLK_OUT = 1'b0;
        LVDS_FRAME   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                LVDS_OUT     = r_shift[3:0];
                LVDS_CLK_OUT = (r_div >= c_div_half);
                LVDS_FRAME   = 1'b1;
                if (w_frame_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Shift datapath: nibble divider, nibble counter, word counter.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_div      <= '0;
            r_nib      <= 3'd0;
            r_word_idx <= 8'd0;
            r_shift    <= 32'd0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_shift <= r_tx_q;
                    r_div   <= '0;
                    r_nib   <= 3'd0;
                end
                S_SHIFT: begin
                    if (w_div_wrap) begin
                        r_div <= '0;
                        r_nib <= r_nib + 3'd1;
                        if (r_nib == 3'd7) begin
                            // Next word was prefetched; no gap between words.
                            r_shift    <= r_tx_q;
                            r_word_idx <= w_word_idx_inc;
                        end else begin
                            r_shift <= {4'd0, r_shift[31:4]};
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: begin
                    r_div      <= '0;
                    r_nib      <= 3'd0;
                    r_word_idx <= 8'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_send.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_send
// Purpose  : Directed self-checking bench for data_send (DIV=2, DEPTH=128).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_send;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [3:0]  lvds_out;
    logic        lvds_clk_out;
    logic        lvds_frame;

    int checks = 0;
    int errors = 0;
    int frame_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (lvds_frame) frame_cnt++;
    end

    data_send dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rstn),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .LVDS_OUT      (lvds_out),
        .LVDS_CLK_OUT  (lvds_clk_out),
        .LVDS_FRAME    (lvds_frame)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the write handshake cycle.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
        int n;
        n = 0;
        awaddr  = addr;
        wdata   = data;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        while (!(awready && wready) && n < 50) begin
            tick();
            n++;
        end
        if (!(awready && wready)) begin
            checks++;
            errors++;
            $display("FAIL axi_write_timeout addr=%h awready=%b wready=%b required 1",
                     addr, awready, wready);
        end
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output int lat);
        int n;
        n = 0;
        araddr  = addr;
        arvalid = 1'b1;
        while (!arready && n < 50) begin
            tick();
            n++;
        end
        if (!arready) begin
            checks++;
            errors++;
            $display("FAIL axi_read_ar_timeout addr=%h arready=%b required 1", addr, arready);
        end
        tick();
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 50) begin
            tick();
            lat++;
        end
        if (!rvalid) begin
            checks++;
            errors++;
            $display("FAIL axi_read_r_timeout addr=%h rvalid=%b required 1", addr, rvalid);
        end
        data = rdata;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int lat;
        rstn = 1'b0;
        repeat (3) tick();
        checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_axi_hs got=%b required 00000",
                     {awready, wready, bvalid, arready, rvalid});
        end
        checks++;
        if (rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdata got=%h required 0", rdata);
        end
        checks++;
        if ({lvds_out, lvds_clk_out, lvds_frame} !== 6'b0) begin
            errors++;
            $display("FAIL reset_lvds got=%b required 000000",
                     {lvds_out, lvds_clk_out, lvds_frame});
        end
        rstn = 1'b1;
        tick();
        axi_read(32'h004, d, lat);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_sr got=%h required 0", d);
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL read_latency got=%0d required 2", lat);
        end
        checks++;
        if (rresp !== 2'b00) begin
            errors++;
            $display("FAIL rresp got=%b required 00", rresp);
        end
        axi_read(32'h008, d, lat);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_len got=%h required 0", d);
        end
    endtask

    task automatic test_single_word();
        logic [31:0] d;
        int lat;
        logic [3:0] exp_nib;
        logic exp_clk;
        axi_write(32'h200, 32'h8765_4321);
        checks++;
        if (bresp !== 2'b00) begin
            errors++;
            $display("FAIL bresp got=%b required 00", bresp);
        end
        axi_write(32'h008, 32'd1);
        axi_write(32'h000, 32'h1);
        // LOAD cycle: frame still low
        checks++;
        if (lvds_frame !== 1'b0) begin
            errors++;
            $display("FAIL single_load_frame got=%b required 0", lvds_frame);
        end
        for (int c = 0; c < 16; c++) begin
            tick();
            exp_nib = 4'((c / 2) + 1);
            exp_clk = ((c % 2) == 1);
            checks++;
            if (lvds_frame !== 1'b1 || lvds_out !== exp_nib || lvds_clk_out !== exp_clk) begin
                errors++;
                $display("FAIL single_nibble c=%0d got frame=%b out=%h clk=%b required 1 %h %b",
                         c, lvds_frame, lvds_out, lvds_clk_out, exp_nib, exp_clk);
            end
        end
        tick();
        checks++;
        if ({lvds_out, lvds_clk_out, lvds_frame} !== 6'b0) begin
            errors++;
            $display("FAIL single_end got=%b required 000000",
                     {lvds_out, lvds_clk_out, lvds_frame});
        end
        axi_read(32'h004, d, lat);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL single_sr got=%h required 2", d);
        end
        axi_write(32'h004, 32'h2);
        axi_read(32'h004, d, lat);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL done_w1c got=%h required 0", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int lat;
        logic [3:0] exp_nib;
        axi_write(32'h200, 32'hFFFF_FFFF);
        axi_write(32'h204, 32'h0000_0000);
        axi_write(32'h008, 32'd2);
        axi_write(32'h000, 32'h1);
        for (int c = 0; c < 32; c++) begin
            tick();
            exp_nib = (c < 16) ? 4'hF : 4'h0;
            checks++;
            if (lvds_frame !== 1'b1 || lvds_out !== exp_nib) begin
                errors++;
                $display("FAIL b2b_nibble c=%0d got frame=%b out=%h required 1 %h",
                         c, lvds_frame, lvds_out, exp_nib);
            end
        end
        tick();
        checks++;
        if (lvds_frame !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end_frame got=%b required 0", lvds_frame);
        end
        axi_read(32'h004, d, lat);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL b2b_sr got=%h required 2", d);
        end
        axi_write(32'h004, 32'h2);
    endtask

    task automatic test_abort();
        logic [31:0] d;
        int lat;
        axi_write(32'h200, 32'h7654_3210);
        axi_write(32'h204, 32'h1111_1111);
        axi_write(32'h208, 32'h2222_2222);
        axi_write(32'h20C, 32'h3333_3333);
        axi_write(32'h008, 32'd4);
        axi_write(32'h000, 32'h1);
        repeat (7) tick();
        checks++;
        if (lvds_frame !== 1'b1 || lvds_out !== 4'h3) begin
            errors++;
            $display("FAIL abort_nib3 got frame=%b out=%h required 1 3", lvds_frame, lvds_out);
        end
        axi_write(32'h000, 32'h3);
        checks++;
        if ({lvds_out, lvds_clk_out, lvds_frame} !== 6'b0) begin
            errors++;
            $display("FAIL abort_outputs got=%b required 000000",
                     {lvds_out, lvds_clk_out, lvds_frame});
        end
        axi_read(32'h004, d, lat);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL abort_sr got=%h required 0", d);
        end
    endtask

    task automatic test_busy_writes();
        logic [31:0] d;
        int lat;
        int fc0;
        axi_write(32'h200, 32'hA5A5_A5A5);
        axi_write(32'h204, 32'h3C3C_3C3C);
        axi_write(32'h008, 32'd2);
        fc0 = frame_cnt;
        axi_write(32'h000, 32'h1);
        axi_write(32'h200, 32'h0);
        axi_write(32'h008, 32'd5);
        axi_write(32'h000, 32'h1);
        repeat (45) tick();
        checks++;
        if (frame_cnt - fc0 !== 32) begin
            errors++;
            $display("FAIL busy_frame_len got=%0d required 32", frame_cnt - fc0);
        end
        axi_read(32'h200, d, lat);
        checks++;
        if (d !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL busy_buf0 got=%h required a5a5a5a5", d);
        end
        axi_read(32'h008, d, lat);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("FAIL busy_len got=%h required 2", d);
        end
        axi_read(32'h004, d, lat);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL busy_sr got=%h required 2", d);
        end
        axi_write(32'h004, 32'h2);
    endtask

    task automatic test_bad_len();
        logic [31:0] d;
        int lat;
        int fc0;
        axi_write(32'h008, 32'd0);
        fc0 = frame_cnt;
        axi_write(32'h000, 32'h1);
        repeat (10) tick();
        checks++;
        if (frame_cnt - fc0 !== 0) begin
            errors++;
            $display("FAIL len0_frame got=%0d required 0", frame_cnt - fc0);
        end
        axi_read(32'h004, d, lat);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL len0_sr got=%h required 0", d);
        end
        axi_write(32'h008, 32'd200);
        fc0 = frame_cnt;
        axi_write(32'h000, 32'h1);
        repeat (10) tick();
        checks++;
        if (frame_cnt - fc0 !== 0) begin
            errors++;
            $display("FAIL lenbig_frame got=%0d required 0", frame_cnt - fc0);
        end
        axi_read(32'h004, d, lat);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL lenbig_sr got=%h required 0", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int lat;
        int fc0;
        axi_read(32'h200, d, lat);
        axi_write(32'h008, 32'd2);
        axi_write(32'h000, 32'h1);
        repeat (5) tick();
        checks++;
        if (lvds_frame !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre_frame got=%b required 1", lvds_frame);
        end
        rstn = 1'b0;
        tick();
        checks++;
        if ({lvds_out, lvds_clk_out, lvds_frame} !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_lvds got=%b required 000000",
                     {lvds_out, lvds_clk_out, lvds_frame});
        end
        checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_axi got hs=%b rdata=%h required 00000 0",
                     {awready, wready, bvalid, arready, rvalid}, rdata);
        end
        rstn = 1'b1;
        fc0 = frame_cnt;
        repeat (20) tick();
        checks++;
        if (frame_cnt - fc0 !== 0) begin
            errors++;
            $display("FAIL rstmid_frame got=%0d required 0", frame_cnt - fc0);
        end
        axi_read(32'h004, d, lat);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_sr got=%h required 0", d);
        end
        axi_read(32'h008, d, lat);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_len got=%h required 0", d);
        end
    endtask

    initial begin
        rstn    = 1'b0;
        awaddr  = 32'd0;
        awvalid = 1'b0;
        wdata   = 32'd0;
        wstrb   = 4'hF;
        wvalid  = 1'b0;
        bready  = 1'b1;
        araddr  = 32'd0;
        arvalid = 1'b0;
        rready  = 1'b1;
        tick();
        test_reset();
        test_single_word();
        test_back_to_back();
        test_abort();
        test_busy_writes();
        test_bad_len();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout reached required finish before limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
